uart_word_tx: RTL and testbench

//  Downstream consumer of the fire stage: accepts one 32-bit word per load pulse (fire ready/data pair),

---
 rtl/uart_word_tx.sv | 172 +++++++++++++++++
 tb/tb_uart_word_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: takes one 32-bit word per load pulse and sends BYTES_PER_WORD
// bytes of it, LSB byte first, as back-to-back UART 8N1 frames on tx_o.
// Also produces the transmitter status word read at 0x30000004.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after the
// data bits, which makes each frame 11 bits long.
module uart_word_tx #(
    parameter int BAUD_DIV       = 434,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overrun_o,
    output logic [31:0] status_o
);

    localparam int                BAUD_W    = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic [31:0]         word_q, word_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic                bit_end;
    logic                accept;
    logic [31:0]         next_word_shift;
    logic [7:0]          next_byte;
`ifdef UART_TX_PARITY_EN
    logic [31:0]         cur_word_shift;
    logic                parity_bit;
`endif

    assign bit_end = (baud_cnt_q == BAUD_LAST);
    // The done_o cycle is already IDLE but still counts as busy for loads.
    assign accept  = word_valid_i && (state_q == S_IDLE) && !done_q;

    assign next_word_shift = word_q >> {byte_idx_q + 2'd1, 3'b000};
    assign next_byte       = next_word_shift[7:0];
`ifdef UART_TX_PARITY_EN
    assign cur_word_shift  = word_q >> {byte_idx_q, 3'b000};
    assign parity_bit      = ^cur_word_shift[7:0];
`endif

    // Next-state, datapath and registered-output values for the frame sequencer.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        baud_cnt_d = (state_q == S_IDLE || bit_end) ? '0 : baud_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        word_d     = word_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q | (word_valid_i & (busy_q | done_q));

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    word_d     = word_i;
                    byte_idx_d = 2'd0;
                    shift_d    = word_i[7:0];
                    busy_d     = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_cnt_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        shift_d    = next_byte;
                        state_d    = S_START;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the state being entered so tx_o changes on the bit edge.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_bit;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // State and output registers with synchronous reset that aborts any frame.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register sees pre-edge values.
        if (rst) begin
            // NOTE: the word buffer is reset too, so no stale data survives a reset.
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            shift_q    <= 8'd0;
            word_q     <= 32'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_o      = tx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign overrun_o = overrun_q;
    assign status_o  = {30'b0, overrun_q, busy_q};

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: drives uart_word_tx (4-byte and 1-byte instances) with
// directed and random words and compares tx_o / status outputs cycle by cycle
// against a frame model built from the UART framing rules.
module tb_uart_word_tx;

    localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int BITS   = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int BITS   = 10;
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] word_i = 32'd0;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic        tx0, busy0, done0, ov0, tx1, busy1, done1, ov1;
    logic [31:0] status0, status1;

    int          tests_run = 0;
    int          fail_cnt  = 0;
    logic [1:0]  ov_model  = 2'b00;
    int          sel       = 0;

    logic        tx_m, busy_m, done_m, ov_m;
    logic [31:0] status_m;

    always #5 clk = ~clk;

    uart_word_tx #(.BAUD_DIV(BAUD), .BYTES_PER_WORD(4)) u0 (
        .clk(clk), .rst(rst), .word_i(word_i), .word_valid_i(valid0),
        .tx_o(tx0), .busy_o(busy0), .done_o(done0), .overrun_o(ov0), .status_o(status0)
    );

    uart_word_tx #(.BAUD_DIV(BAUD), .BYTES_PER_WORD(1)) u1 (
        .clk(clk), .rst(rst), .word_i(word_i), .word_valid_i(valid1),
        .tx_o(tx1), .busy_o(busy1), .done_o(done1), .overrun_o(ov1), .status_o(status1)
    );

    always_comb begin
        tx_m     = (sel != 0) ? tx1     : tx0;
        busy_m   = (sel != 0) ? busy1   : busy0;
        done_m   = (sel != 0) ? done1   : done0;
        ov_m     = (sel != 0) ? ov1     : ov0;
        status_m = (sel != 0) ? status1 : status0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level k cycles after the accepting edge: frames of BITS bits,
    // each held BAUD cycles; start=0, data LSB first, optional even parity, stop=1.
    function automatic logic exp_bit(input logic [31:0] w, input int k);
        int         b, byt, pos;
        logic [7:0] data;
        b    = k / BAUD;
        byt  = b / BITS;
        pos  = b % BITS;
        data = 8'((w >> (8 * byt)) & 32'hFF);
        if (pos == 0)            return 1'b0;
        if (pos <= 8)            return data[pos-1];
        if (PAR_EN && pos == 9)  return ^data;
        return 1'b1;
    endfunction

    function automatic int word_cycles(input int s);
        return ((s != 0) ? 1 : 4) * BITS * BAUD;
    endfunction

    task automatic set_valid(input int s, input logic v);
        if (s != 0) valid1 = v;
        else        valid0 = v;
    endtask

    // Sends one word on instance s; optionally pulses a second load at offset inject_at.
    task automatic run_word(input int s, input logic [31:0] w, input int inject_at,
                            input logic [31:0] inj_w);
        int cyc;
        sel   = s;
        cyc   = word_cycles(s);
        word_i = w;
        set_valid(s, 1'b1);
        tick();
        set_valid(s, 1'b0);
        for (int k = 0; k < cyc; k++) begin
            check($sformatf("tx w=%08h k=%0d", w, k), {31'b0, tx_m}, {31'b0, exp_bit(w, k)});
            check("busy in frame", {31'b0, busy_m}, 32'd1);
            check("done in frame", {31'b0, done_m}, 32'd0);
            if (k == inject_at) begin
                word_i = inj_w;
                set_valid(s, 1'b1);
                ov_model[s] = 1'b1;
            end
            tick();
            set_valid(s, 1'b0);
        end
        check("done pulse", {31'b0, done_m}, 32'd1);
        check("busy at done", {31'b0, busy_m}, 32'd0);
        check("tx at done", {31'b0, tx_m}, 32'd1);
        check("overrun", {31'b0, ov_m}, {31'b0, ov_model[s]});
        check("status", status_m, {30'b0, ov_model[s], 1'b0});
    endtask

    task automatic idle_cycles(input int s, input int n);
        sel = s;
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle tx", {31'b0, tx_m}, 32'd1);
            check("idle busy", {31'b0, busy_m}, 32'd0);
            check("idle done", {31'b0, done_m}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        ov_model = 2'b00;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            check("rst tx", {31'b0, tx_m}, 32'd1);
            check("rst busy", {31'b0, busy_m}, 32'd0);
            check("rst done", {31'b0, done_m}, 32'd0);
            check("rst status", status_m, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] w;
        int          inj;

        // Power-on reset.
        do_reset();

        // Basic word, then a word with an overlapping load (overrun, data unchanged).
        run_word(0, 32'h0000_00A5, -1, 32'd0);
        idle_cycles(0, 3);
        run_word(0, 32'h0000_00A5, 50, 32'hFFFF_FFFF);

        // Load one cycle after done_o is accepted and runs with no inter-byte gap.
        tick();
        run_word(0, 32'h1234_5678, -1, 32'd0);

        // Load during the done_o cycle is ignored and flags overrun.
        do_reset();
        run_word(0, $urandom, -1, 32'd0);
        word_i = $urandom;
        valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        ov_model[0] = 1'b1;
        check("done-cycle load busy", {31'b0, busy0}, 32'd0);
        check("done-cycle load ovr", {31'b0, ov0}, 32'd1);
        idle_cycles(0, 5);

        // Parity pattern word (parity bits 1 then 0 when parity is built in).
        tick();
        run_word(0, 32'h0000_0007, -1, 32'd0);

        // Single-byte instance.
        tick();
        run_word(1, 32'hDEAD_BE55, -1, 32'd0);
        idle_cycles(1, 2);

        // Random words on both instances, some with overlapping loads.
        for (int i = 0; i < 8; i++) begin
            int s;
            s   = int'($urandom_range(0, 1));
            w   = $urandom;
            inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, word_cycles(s) - 1)) : -1;
            run_word(s, w, inj, $urandom);
            idle_cycles(s, int'($urandom_range(1, 3)));
        end

        // Reset in the middle of a frame aborts it and clears overrun.
        sel    = 0;
        w      = $urandom;
        word_i = w;
        valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            check("pre-abort tx", {31'b0, tx0}, {31'b0, exp_bit(w, k)});
            if (k == 10) begin
                valid0 = 1'b1;
                ov_model[0] = 1'b1;
            end
            tick();
            valid0 = 1'b0;
        end
        check("pre-abort ovr", {31'b0, ov0}, 32'd1);
        rst = 1'b1;
        tick();
        check("abort tx", {31'b0, tx0}, 32'd1);
        check("abort busy", {31'b0, busy0}, 32'd0);
        check("abort done", {31'b0, done0}, 32'd0);
        check("abort ovr", {31'b0, ov0}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        ov_model = 2'b00;
        idle_cycles(0, 200);
        check("post-abort status", status0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
